// File: rtl/rot_share_arbiter.sv
// Round-robin front end that shares one pipelined barrel rotator among NUM_REQ requesters.
// Optional ROT_ARB_RIGHT_EN: req_dir=1 turns the rotation into a right rotate by negating the amount.
module rot_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_STAGES = 1,
    parameter int NUM_REQ    = 4,
    localparam int SA_WIDTH  = $clog2(DATA_WIDTH),
    localparam int ID_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    input  logic [NUM_REQ*SA_WIDTH-1:0]    req_shamt,
    input  logic [NUM_REQ-1:0]             req_dir,
    input  logic                           hold,
    output logic [DATA_WIDTH-1:0]          rot_data_in,
    output logic [SA_WIDTH-1:0]            rot_shift_amount,
    input  logic [DATA_WIDTH-1:0]          rot_data_out,
    output logic                           rsp_valid,
    output logic [ID_WIDTH-1:0]            rsp_id,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic                           busy
);

    logic [ID_WIDTH-1:0]   last_reg;
    logic                  issue_valid_reg;
    logic [ID_WIDTH-1:0]   issue_id_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic [SA_WIDTH-1:0]   amount_reg;

    logic [NUM_STAGES-1:0] tag_valid_reg;
    logic [ID_WIDTH-1:0]   tag_id_reg [NUM_STAGES];

    logic                  rsp_valid_reg;
    logic [ID_WIDTH-1:0]   rsp_id_reg;
    logic [DATA_WIDTH-1:0] rsp_data_reg;

    logic                  grant_found;
    logic [ID_WIDTH-1:0]   winner;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [SA_WIDTH-1:0]   sel_shamt;
    logic [SA_WIDTH-1:0]   amount_next;

    // Search starts just after the last grant and wraps, so every requester is reached within NUM_REQ grants.
    always_comb begin
        logic [ID_WIDTH:0] cand;
        grant_found = 1'b0;
        winner      = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_reg} + (ID_WIDTH+1)'(k);
            if (cand >= (ID_WIDTH+1)'(NUM_REQ)) begin
                cand = cand - (ID_WIDTH+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[cand[ID_WIDTH-1:0]]) begin
                grant_found = 1'b1;
                winner      = cand[ID_WIDTH-1:0];
            end
        end
    end

    assign accept    = grant_found && !hold;
    assign sel_data  = req_data[winner*DATA_WIDTH +: DATA_WIDTH];
    assign sel_shamt = req_shamt[winner*SA_WIDTH +: SA_WIDTH];

`ifdef ROT_ARB_RIGHT_EN
    assign amount_next = req_dir[winner] ? (SA_WIDTH'(0) - sel_shamt) : sel_shamt;
`else
    logic unused_dir;
    assign unused_dir  = ^req_dir;
    assign amount_next = sel_shamt;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = accept && (winner == ID_WIDTH'(gi));
        end
    endgenerate

    // Operand registers only load on accept so the rotator inputs stay quiet when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_reg        <= ID_WIDTH'(NUM_REQ-1);
            issue_valid_reg <= 1'b0;
            issue_id_reg    <= '0;
            data_reg        <= '0;
            amount_reg      <= '0;
        end else begin
            issue_valid_reg <= accept;
            if (accept) begin
                last_reg     <= winner;
                issue_id_reg <= winner;
                data_reg     <= sel_data;
                amount_reg   <= amount_next;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_valid_reg <= '0;
            for (int s = 0; s < NUM_STAGES; s++) begin
                tag_id_reg[s] <= '0;
            end
        end else begin
            tag_valid_reg[0] <= issue_valid_reg;
            tag_id_reg[0]    <= issue_id_reg;
            for (int s = 1; s < NUM_STAGES; s++) begin
                tag_valid_reg[s] <= tag_valid_reg[s-1];
                tag_id_reg[s]    <= tag_id_reg[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_data_reg  <= '0;
        end else begin
            rsp_valid_reg <= tag_valid_reg[NUM_STAGES-1];
            if (tag_valid_reg[NUM_STAGES-1]) begin
                rsp_id_reg   <= tag_id_reg[NUM_STAGES-1];
                rsp_data_reg <= rot_data_out;
            end
        end
    end

    assign rot_data_in      = data_reg;
    assign rot_shift_amount = amount_reg;
    assign rsp_valid        = rsp_valid_reg;
    assign rsp_id           = rsp_id_reg;
    assign rsp_data         = rsp_data_reg;
    assign busy             = issue_valid_reg || (|tag_valid_reg) || rsp_valid_reg;

endmodule

// File: tb/tb_rot_share_arbiter.sv
// Bench for rot_share_arbiter: behavioural rotator pipeline, round-robin reference and response scoreboard.
module tb_rot_share_arbiter;
    localparam int DW  = 8;
    localparam int NS  = 2;
    localparam int NR  = 4;
    localparam int SAW = 3;
    localparam int IDW = 2;

    logic              clk;
    logic              reset_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_data;
    logic [NR*SAW-1:0] req_shamt;
    logic [NR-1:0]     req_dir;
    logic              hold;
    logic [DW-1:0]     rot_data_in;
    logic [SAW-1:0]    rot_shift_amount;
    logic [DW-1:0]     rot_data_out;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [DW-1:0]     rsp_data;
    logic              busy;

    rot_share_arbiter #(.DATA_WIDTH(DW), .NUM_STAGES(NS), .NUM_REQ(NR)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_shamt(req_shamt), .req_dir(req_dir), .hold(hold),
        .rot_data_in(rot_data_in), .rot_shift_amount(rot_shift_amount),
        .rot_data_out(rot_data_out), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rotl(input logic [DW-1:0] d, input int s);
        logic [DW-1:0] r = d;
        for (int i = 0; i < s; i++) r = {r[DW-2:0], r[DW-1]};
        return r;
    endfunction

    function automatic logic [DW-1:0] rotr(input logic [DW-1:0] d, input int s);
        logic [DW-1:0] r = d;
        for (int i = 0; i < s; i++) r = {r[0], r[DW-1:1]};
        return r;
    endfunction

    // External rotator model: NS register stages, left rotate.
    logic [DW-1:0] rot_pipe [NS];
    always_ff @(posedge clk) begin
        rot_pipe[0] <= rotl(rot_data_in, int'(rot_shift_amount));
        for (int s = 1; s < NS; s++) rot_pipe[s] <= rot_pipe[s-1];
    end
    assign rot_data_out = rot_pipe[NS-1];

    typedef struct {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
        int             due;
    } exp_t;

    typedef struct {
        logic [NR-1:0] valid;
        logic          hold;
        logic [NR-1:0] ready;
    } vec_t;

    exp_t          sbq[$];
    logic [DW-1:0] rsp_log[$];
    vec_t          tbl [15];
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            mdl_last = NR-1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_lane(input int i, input logic [DW-1:0] d, input logic [SAW-1:0] s, input logic dir);
        req_data[i*DW +: DW]    = d;
        req_shamt[i*SAW +: SAW] = s;
        req_dir[i]              = dir;
    endtask

    task automatic randomize_lanes();
        for (int i = 0; i < NR; i++)
            set_lane(i, DW'($urandom_range(0, 255)), SAW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    endtask

    // Predicts the grant, queues the expected response, and retires responses from the DUT.
    task automatic monitor();
        int w;
        logic [NR-1:0] exp_rdy;
        logic [DW-1:0] d;
        int s;
        exp_t e;
        if (!reset_n) begin
            sbq.delete();
            mdl_last = NR-1;
            return;
        end
        w = -1;
        for (int k = 1; k <= NR; k++) begin
            int idx = (mdl_last + k) % NR;
            if (w < 0 && req_valid[idx]) w = idx;
        end
        exp_rdy = (w >= 0 && !hold) ? NR'(1 << w) : '0;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (w >= 0 && !hold) begin
            d = req_data[w*DW +: DW];
            s = int'(req_shamt[w*SAW +: SAW]);
`ifdef ROT_ARB_RIGHT_EN
            e.data = req_dir[w] ? rotr(d, s) : rotl(d, s);
`else
            e.data = rotl(d, s);
`endif
            e.id  = IDW'(w);
            e.due = cyc + NS + 2;
            sbq.push_back(e);
            mdl_last = w;
        end
        if (rsp_valid) begin
            rsp_log.push_back(rsp_data);
            if (sbq.size() == 0) begin
                chk("rsp_spurious_id", 32'(rsp_id), 32'hFFFF);
            end else begin
                e = sbq.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_data", 32'(rsp_data), 32'(e.data));
                chk("rsp_latency", 32'(cyc), 32'(e.due));
            end
        end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            chk("rsp_missing_valid", 32'(rsp_valid), 32'(1));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rot_data_in"}, 32'(rot_data_in), 32'(0));
        chk({tag, "_rot_shift_amount"}, 32'(rot_shift_amount), 32'(0));
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
        chk({tag, "_rsp_id"}, 32'(rsp_id), 32'(0));
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
    endtask

    initial begin
        tbl[0]  = '{4'b1111, 1'b0, 4'b0001};
        tbl[1]  = '{4'b1111, 1'b0, 4'b0010};
        tbl[2]  = '{4'b1111, 1'b0, 4'b0100};
        tbl[3]  = '{4'b1111, 1'b0, 4'b1000};
        tbl[4]  = '{4'b1111, 1'b0, 4'b0001};
        tbl[5]  = '{4'b1111, 1'b0, 4'b0010};
        tbl[6]  = '{4'b1111, 1'b0, 4'b0100};
        tbl[7]  = '{4'b1111, 1'b0, 4'b1000};
        tbl[8]  = '{4'b1010, 1'b1, 4'b0000};
        tbl[9]  = '{4'b1010, 1'b0, 4'b0010};
        tbl[10] = '{4'b1010, 1'b0, 4'b1000};
        tbl[11] = '{4'b0000, 1'b0, 4'b0000};
        tbl[12] = '{4'b0100, 1'b0, 4'b0100};
        tbl[13] = '{4'b0101, 1'b0, 4'b0001};
        tbl[14] = '{4'b1001, 1'b0, 4'b1000};

        reset_n = 1'b0; req_valid = '0; req_data = '0; req_shamt = '0; req_dir = '0; hold = 1'b0;
        #2;
        chk_reset_state("reset");
        tick();
        tick();
        reset_n = 1'b1;

        // Single operation: 0x81 rotl 1 -> 0x03, fixed latency, then idle.
        set_lane(0, 8'h81, 3'd1, 1'b0);
        req_valid = 4'b0001;
        #1 chk("single_ready", 32'(req_ready), 32'(4'b0001));
        tick();
        req_valid = '0;
        for (int i = 0; i < 4; i++) tick();
        chk("single_busy_after", 32'(busy), 32'(0));
        chk("single_rsp_data_held", 32'(rsp_data), 32'(8'h03));
        chk("idle_rot_data_in_held", 32'(rot_data_in), 32'(8'h81));
        chk("idle_rot_shift_held", 32'(rot_shift_amount), 32'(1));

        // Round-robin vectors; pointer is at 0 after the single op, so realign with a grant to 3.
        req_valid = 4'b1000;
        tick();
        for (int i = 0; i < 15; i++) begin
            req_valid = tbl[i].valid;
            hold      = tbl[i].hold;
            randomize_lanes();
            #1 chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].ready));
            tick();
        end
        req_valid = '0; hold = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // hold with req1/req2 pending and one op (req0) in flight.
        set_lane(0, 8'h5A, 3'd3, 1'b0);
        req_valid = 4'b0001;
        tick();
        hold = 1'b1;
        req_valid = 4'b0110;
        for (int i = 0; i < 5; i++) begin
            #1 chk("hold_ready", 32'(req_ready), 32'(0));
            tick();
        end
        hold = 1'b0;
        #1 chk("hold_release_ready", 32'(req_ready), 32'(4'b0010));
        tick();
        req_valid = '0;
        for (int i = 0; i < 6; i++) tick();

        // Direction handling on requester 2, including a zero amount.
        rsp_log.delete();
        set_lane(2, 8'h81, 3'd1, 1'b1);
        req_valid = 4'b0100;
        tick();
        set_lane(2, 8'h81, 3'd0, 1'b1);
        tick();
        req_valid = '0;
        for (int i = 0; i < 6; i++) tick();
        chk("dir_rsp_count", 32'(rsp_log.size()), 32'(2));
        if (rsp_log.size() == 2) begin
`ifdef ROT_ARB_RIGHT_EN
            chk("dir_right1", 32'(rsp_log[0]), 32'(8'hC0));
`else
            chk("dir_ignored", 32'(rsp_log[0]), 32'(8'h03));
`endif
            chk("dir_shamt0", 32'(rsp_log[1]), 32'(8'h81));
        end

        // Reset two cycles after three accepts; nothing from them may emerge after release.
        randomize_lanes();
        req_valid = 4'b1111;
        for (int i = 0; i < 3; i++) tick();
        req_valid = '0;
        tick();
        tick();
        reset_n = 1'b0;
        #1 chk_reset_state("midreset");
        tick();
        tick();
        reset_n = 1'b1;

        // req3 pulses for one cycle alongside req0; only req0 may be granted and answered.
        req_valid = 4'b1001;
        #1 chk("post_reset_ready", 32'(req_ready), 32'(4'b0001));
        tick();
        req_valid = '0;
        for (int i = 0; i < 8; i++) tick();
        chk("queue_empty", 32'(sbq.size()), 32'(0));
        chk("final_busy", 32'(busy), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rot_share_arbiter.md
Name: rot_share_arbiter

Overview:
- Shares one pipelined barrel rotator instance among NUM_REQ requesters.
- Round-robin arbitration, one issue per cycle.
- Tags each issued operation and tracks it through the rotator's fixed latency; routes each result back with the requester id.
- Sits between client units (crypto/hash mixers, bit-field extractors) and the rotator datapath; the rotator instance lives outside this block.

Parameters:
- DATA_WIDTH, 32: rotator data width; power of two, at least 2.
- NUM_STAGES, 1: rotator pipeline depth; must match the instance; at least 1.
- NUM_REQ, 4: number of requesters, 2 to 16.
- SA_WIDTH, $clog2(DATA_WIDTH): rotate-amount width (derived localparam).
- ID_WIDTH, $clog2(NUM_REQ): requester id width (derived localparam).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant/accept.
- req_data  in  NUM_REQ*DATA_WIDTH  operands; requester i at slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_shamt  in  NUM_REQ*SA_WIDTH  rotate amounts, sliced the same way.
- req_dir  in  NUM_REQ  1 = rotate right, 0 = left; used only with ROT_ARB_RIGHT_EN.
- hold  in  1  when high, no new grants; in-flight operations drain.
- rot_data_in  out  DATA_WIDTH  to rotator data_in.
- rot_shift_amount  out  SA_WIDTH  to rotator shift_amount.
- rot_data_out  in  DATA_WIDTH  from rotator data_out.
- rsp_valid  out  1  result valid, single-cycle pulse per operation.
- rsp_id  out  ID_WIDTH  requester that owns rsp_data.
- rsp_data  out  DATA_WIDTH  rotated result.
- busy  out  1  any operation in the issue register or tag pipeline.

Behaviour:
- Reset (async assert, sync release):
  - rot_data_in = 0, rot_shift_amount = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0, busy = 0.
  - Tag pipeline cleared; round-robin last-grant pointer = NUM_REQ-1, so requester 0 has top priority first.
- Arbitration (combinational):
  - Scan from (last+1) mod NUM_REQ upward with wrap; first asserted req_valid wins.
  - req_ready[i] = winner==i and !hold; at most one bit high.
  - req_ready does not depend on rsp side; there is no response backpressure.
- Accept: req_valid[i] & req_ready[i] at edge t.
  - Pointer becomes i.
  - Issue register loads data and amount; issue valid = 1, issue id = i.
  - With no accept, issue valid = 0, and rot_data_in / rot_shift_amount hold their previous values (no toggling).
- Issue register drives rot_data_in / rot_shift_amount during cycle t+1.
- Tag pipeline:
  - NUM_STAGES entries of {valid, id}, shifted every cycle, aligned with the rotator's registers.
  - The last entry qualifies rot_data_out.
- Response:
  - rsp_valid / rsp_id / rsp_data are registered from the last tag entry and rot_data_out.
  - Accept at edge t gives rsp_valid high in cycle t+NUM_STAGES+2, i.e. fixed latency NUM_STAGES+2 edges.
  - rsp_data holds its last value when rsp_valid = 0.
- Throughput: one accept per cycle sustained; back-to-back results come out in issue order.
- busy = issue valid OR any tag valid OR rsp_valid.
- hold:
  - Takes effect on the same cycle it is sampled.
  - Requests already accepted complete normally.
  - Deassertion resumes round-robin from the stored pointer.
- Requester behaviour: a requester may drop req_valid without being granted (no penalty). Payload must be stable only in the cycle req_ready is high.
- Reset mid-operation: all in-flight operations are discarded, and no rsp_valid is produced for them after release.
- Amount wrap: shift amount 0 is a pass-through op and still produces rsp_valid.

Optional Feature:
- ROT_ARB_RIGHT_EN defined:
  - A request with req_dir = 1 is converted at accept time to left amount = (0 - req_shamt) mod 2^SA_WIDTH.
  - Right by 0 stays 0.
  - Latency is unchanged.
- Undefined: req_dir is ignored and all requests rotate left.

Test Plan:
- DATA_WIDTH=8, NUM_STAGES=2, NUM_REQ=4; req0 data 0x81, shamt 1, accepted at edge t -> rsp_valid in cycle t+4, rsp_id 0, rsp_data 0x03, busy low afterwards.
- All four req_valid held high for 8 cycles -> grants 0,1,2,3,0,1,2,3; rsp_id follows the same order, one per cycle, no gaps.
- Reset pulse two cycles after three accepts -> no rsp_valid after release; all outputs 0; the next grant goes to requester 0.
- hold raised while req1 and req2 are pending and one op is in flight -> the in-flight rsp still arrives, req_ready stays 0; after hold drops, req1 is granted first.
- ROT_ARB_RIGHT_EN defined: req2 data 0x81, dir 1, shamt 1 -> rsp_data 0xC0; dir 1, shamt 0 -> 0x81. Undefined: the first case gives 0x03.
- req_valid[3] pulsed one cycle while req0 is being granted, then dropped -> only req0 produces a response; no spurious rsp for id 3.
